// File: rtl/maxpool_layer1_if.sv
// Shared memory bus and control strobes between the
// max-pool block and the layer memories.
interface maxpool_layer1_if #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  crd;
  logic [ADDR_WIDTH-1:0] caddr_rd;
  logic [DATA_WIDTH-1:0] cdata_rd;
  logic                  cwr;
  logic [ADDR_WIDTH-1:0] caddr_wr;
  logic [DATA_WIDTH-1:0] cdata_wr;
  logic [2:0]            csel;

  modport master (
    input  start, cdata_rd,
    output busy, done, crd, caddr_rd,
    output cwr, caddr_wr, cdata_wr, csel
  );

  modport slave (
    output start, cdata_rd,
    input  busy, done, crd, caddr_rd,
    input  cwr, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/maxpool_layer1.sv
// 2x2 stride-2 max-pool: reads Layer 0 back over the
// shared bus and writes the pooled image into Layer 1.
module maxpool_layer1 #(
  parameter int DATA_WIDTH  = 20,
  parameter int ADDR_WIDTH  = 12,
  parameter int IMAGE_WIDTH = 64
) (
  input logic               clk,
  input logic               reset,
  maxpool_layer1_if.master  bus
);
  localparam int HALF = IMAGE_WIDTH / 2;
  localparam int CW   = $clog2(HALF);

  typedef enum logic [2:0] {
    IDLE, RD0, RD1, RD2, RD3, CMP, WR, FIN
  } state_t;

  state_t                r_state, w_next;
  logic [CW-1:0]         r_row, r_col;
  logic [CW-1:0]         w_row_nxt, w_col_nxt;
  logic [DATA_WIDTH-1:0] r_max, w_max_nxt;
  logic                  w_last, w_smp;

  logic                  w_rd;
  logic [ADDR_WIDTH-1:0] w_base, w_rd_addr, w_wr_addr;

  logic                  r_busy, r_done;
  logic                  r_crd, r_cwr;
  logic [2:0]            r_csel;
  logic [ADDR_WIDTH-1:0] r_caddr_rd, r_caddr_wr;
  logic [DATA_WIDTH-1:0] r_cdata_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_max   <= '0;
    end else begin
      r_state <= w_next;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_max   <= w_max_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    w_max_nxt = r_max;
    w_smp     = 1'b0;
    w_last    = (r_row == CW'(HALF-1)) &&
                (r_col == CW'(HALF-1));
    unique case (r_state)
      IDLE: if (bus.start) begin
        w_next    = RD0;
        w_row_nxt = '0;
        w_col_nxt = '0;
      end
      RD0: w_next = RD1;
      RD1: begin
        w_next    = RD2;
        w_max_nxt = bus.cdata_rd;
      end
      RD2: begin
        w_next = RD3;
        w_smp  = 1'b1;
      end
      RD3: begin
        w_next = CMP;
        w_smp  = 1'b1;
      end
      CMP: begin
        w_next = WR;
        w_smp  = 1'b1;
      end
      WR: begin
        w_next = w_last ? FIN : RD0;
        if (r_col == CW'(HALF-1)) begin
          w_col_nxt = '0;
          w_row_nxt = r_row + 1'b1;
        end else begin
          w_col_nxt = r_col + 1'b1;
        end
      end
      FIN: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // ties keep the held value
    if (w_smp && (bus.cdata_rd > r_max))
      w_max_nxt = bus.cdata_rd;
  end

  always_comb begin
    w_base = ADDR_WIDTH'(2 * int'(w_row_nxt) * IMAGE_WIDTH
                        + 2 * int'(w_col_nxt));
    w_wr_addr = ADDR_WIDTH'(int'(r_row) * HALF
                            + int'(r_col));
    w_rd      = 1'b0;
    w_rd_addr = w_base;
    unique case (w_next)
      RD0: w_rd = 1'b1;
      RD1: begin
        w_rd      = 1'b1;
        w_rd_addr = w_base + ADDR_WIDTH'(1);
      end
      RD2: begin
        w_rd      = 1'b1;
        w_rd_addr = w_base + ADDR_WIDTH'(IMAGE_WIDTH);
      end
      RD3: begin
        w_rd      = 1'b1;
        w_rd_addr = w_base + ADDR_WIDTH'(IMAGE_WIDTH + 1);
      end
      default: w_rd = 1'b0;
    endcase
  end

  // outputs registered from next state: stable all cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_csel     <= 3'b000;
      r_caddr_rd <= '0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
    end else begin
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == FIN);
      r_crd  <= w_rd;
      r_cwr  <= (w_next == WR);
      r_csel <= w_rd ? 3'b001 :
                (w_next == WR) ? 3'b011 : 3'b000;
      if (w_rd)
        r_caddr_rd <= w_rd_addr;
      if (w_next == WR) begin
        r_caddr_wr <= w_wr_addr;
        r_cdata_wr <= w_max_nxt;
      end
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.crd      = r_crd;
  assign bus.cwr      = r_cwr;
  assign bus.csel     = r_csel;
  assign bus.caddr_rd = r_caddr_rd;
  assign bus.caddr_wr = r_caddr_wr;
  assign bus.cdata_wr = r_cdata_wr;
endmodule

// File: tb/tb_maxpool_layer1.sv
// Randomized scoreboard bench for maxpool_layer1 with a
// behavioural layer-memory model and protocol monitor.
module tb_maxpool_layer1;
  localparam int DW = 20;
  localparam int AW = 12;
  localparam int IW = 64;
  localparam int OW = IW / 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  maxpool_layer1_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mbus();

  maxpool_layer1 #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMAGE_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .bus(mbus)
  );

  logic [DW-1:0] layer0 [IW*IW];
  logic [DW-1:0] layer1 [OW*OW];

  int checks = 0;
  int errors = 0;
  int exp_rd_q[$];
  int exp_wa_q[$];
  int exp_wd_q[$];

  int  cyc = 0;
  int  t_rd0 = 0;
  int  done_lat = -1;
  int  done_cnt = 0;
  int  wr_cnt = 0;
  bit  active = 0;
  bit  prev_done = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // Layer-0 memory: data one cycle after the strobe,
  // garbage otherwise so mistimed sampling shows up.
  always @(posedge clk) begin
    if (mbus.crd && mbus.csel == 3'b001)
      mbus.cdata_rd <= layer0[mbus.caddr_rd];
    else
      mbus.cdata_rd <= DW'($urandom);
  end

  always @(negedge clk) begin
    if (reset) begin
      cyc++;
      chk("rd_wr_excl", int'(mbus.crd && mbus.cwr), 0);
      chk("csel", int'(mbus.csel),
          mbus.crd ? 1 : (mbus.cwr ? 3 : 0));
      if (prev_done)
        chk("busy_after_done", int'(mbus.busy), 0);
      prev_done = mbus.done;
      if (mbus.crd) begin
        if (!active) begin
          active = 1;
          t_rd0  = cyc;
        end
        if (exp_rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_extra actual=%0h required=none",
                   mbus.caddr_rd);
        end else begin
          chk("rd_addr", int'(mbus.caddr_rd),
              exp_rd_q.pop_front());
        end
      end
      if (active)
        chk("busy_run", int'(mbus.busy), 1);
      if (mbus.cwr) begin
        layer1[mbus.caddr_wr[9:0]] = mbus.cdata_wr;
        wr_cnt++;
        if (exp_wa_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_extra actual=%0h required=none",
                   mbus.caddr_wr);
        end else begin
          chk("wr_addr", int'(mbus.caddr_wr),
              exp_wa_q.pop_front());
          chk("wr_data", int'(mbus.cdata_wr),
              exp_wd_q.pop_front());
        end
      end
      if (mbus.done) begin
        done_cnt++;
        done_lat = cyc - t_rd0;
        active   = 0;
      end
    end
  end

  // Reference: for each output pixel the four window reads
  // in order, then the largest of the four values.
  task automatic push_expected();
    int b, m, a;
    for (int r = 0; r < OW; r++) begin
      for (int c = 0; c < OW; c++) begin
        b = 2 * r * IW + 2 * c;
        m = 0;
        for (int k = 0; k < 4; k++) begin
          a = b + (k % 2) + (k / 2) * IW;
          exp_rd_q.push_back(a);
          if (int'(layer0[a]) > m) m = int'(layer0[a]);
        end
        exp_wa_q.push_back(r * OW + c);
        exp_wd_q.push_back(m);
      end
    end
  endtask

  task automatic run_image(input string tag, input bit extra,
                           input int abort_at);
    push_expected();
    for (int i = 0; i < OW*OW; i++) layer1[i] = '1;
    wr_cnt   = 0;
    done_cnt = 0;
    done_lat = -1;
    active   = 0;
    @(posedge clk); #1 mbus.start = 1'b1;
    @(posedge clk); #1 mbus.start = 1'b0;
    for (int i = 0; i < 7000; i++) begin
      if (done_cnt != 0) break;
      if (abort_at != 0 && wr_cnt >= abort_at) break;
      @(posedge clk); #1;
      mbus.start = extra && (i % 1000 == 500);
    end
    mbus.start = 1'b0;
    if (abort_at != 0) return;
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_latency"}, done_lat, 6144);
    chk({tag, "_wr_cnt"}, wr_cnt, 1024);
    chk({tag, "_q_left"},
        exp_rd_q.size() + exp_wa_q.size(), 0);
  endtask

  task automatic fill_zero();
    for (int a = 0; a < IW*IW; a++) layer0[a] = '0;
  endtask

  task automatic fill_rand();
    for (int a = 0; a < IW*IW; a++) layer0[a] = DW'($urandom);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctrl"}, int'({mbus.busy, mbus.done, mbus.crd,
                              mbus.cwr, mbus.csel}), 0);
    chk({tag, "_caddr_rd"}, int'(mbus.caddr_rd), 0);
    chk({tag, "_caddr_wr"}, int'(mbus.caddr_wr), 0);
    chk({tag, "_cdata_wr"}, int'(mbus.cdata_wr), 0);
  endtask

  task automatic count_nonzero_rest(input string tag);
    int nz;
    nz = 0;
    for (int i = 1; i < OW*OW; i++)
      if (layer1[i] != '0) nz++;
    chk({tag, "_others_zero"}, nz, 0);
  endtask

  initial begin
    int pos [4];
    pos[0] = 0;
    pos[1] = 1;
    pos[2] = IW;
    pos[3] = IW + 1;
    mbus.start    = 1'b0;
    mbus.cdata_rd = '0;
    fill_zero();
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk) reset = 1'b1;

    for (int a = 0; a < IW*IW; a++) layer0[a] = DW'(a);
    run_image("ramp", 1'b0, 0);
    chk("ramp_l1_0", int'(layer1[0]), 65);
    chk("ramp_l1_1", int'(layer1[1]), 67);
    chk("ramp_l1_32", int'(layer1[32]), 193);
    chk("ramp_l1_1023", int'(layer1[1023]), 4095);

    for (int p = 0; p < 4; p++) begin
      fill_zero();
      layer0[pos[p]] = 20'hFFFFF;
      run_image("sweep", 1'b0, 0);
      chk("sweep_l1_0", int'(layer1[0]), 20'hFFFFF);
      count_nonzero_rest("sweep");
    end

    fill_zero();
    layer0[1]  = 20'h5A5A5;
    layer0[IW] = 20'h5A5A5;
    run_image("tie", 1'b0, 0);
    chk("tie_l1_0", int'(layer1[0]), 20'h5A5A5);

    fill_rand();
    run_image("rand_extra_start", 1'b1, 0);

    fill_rand();
    run_image("abort", 1'b0, 500);
    chk("abort_reached_500", int'(wr_cnt >= 500), 1);
    #1 reset = 1'b0;
    #1 check_outputs_zero("async_rst");
    exp_rd_q.delete();
    exp_wa_q.delete();
    exp_wd_q.delete();
    active    = 0;
    prev_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    fill_rand();
    run_image("restart", 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
